// File: rtl/ctrl_decode_pipe_pkg.sv
// ctrl_decode_pipe_pkg: opcodes, ALU codes, memory sizes, operand-A selects and the control bundle type
package ctrl_decode_pipe_pkg;
  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] I_TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] S_TYPE      = 7'b0100011;
  localparam logic [6:0] B_TYPE      = 7'b1100011;
  localparam logic [6:0] I_JALR      = 7'b1100111;
  localparam logic [6:0] J_JAL       = 7'b1101111;
  localparam logic [6:0] U_AUIPC     = 7'b0010111;
  localparam logic [6:0] U_LUI       = 7'b0110111;
  localparam logic [5:0] ADD     = 6'd0;
  localparam logic [5:0] SUB     = 6'd1;
  localparam logic [5:0] SLL     = 6'd2;
  localparam logic [5:0] SLT     = 6'd3;
  localparam logic [5:0] SLTU    = 6'd4;
  localparam logic [5:0] XOR     = 6'd5;
  localparam logic [5:0] SRL     = 6'd6;
  localparam logic [5:0] SRA     = 6'd7;
  localparam logic [5:0] OR      = 6'd8;
  localparam logic [5:0] AND     = 6'd9;
  localparam logic [5:0] BEQ     = 6'd10;
  localparam logic [5:0] BNE     = 6'd11;
  localparam logic [5:0] BLT     = 6'd12;
  localparam logic [5:0] BGE     = 6'd13;
  localparam logic [5:0] BLTU    = 6'd14;
  localparam logic [5:0] BGEU    = 6'd15;
  localparam logic [5:0] JAL     = 6'd16;
  localparam logic [5:0] JALR    = 6'd17;
  localparam logic [5:0] DEFAULT = 6'd63;
  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HWORD = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_PC4  = 2'b10;
  localparam logic [1:0] OPA_ZERO = 2'b11;
  typedef struct packed {
    logic       wEn;
    logic       branch_op;
    logic [1:0] op_A_sel;
    logic       op_B_sel;
    logic [5:0] alu;
    logic       mem_wEn;
    logic [1:0] mem_size;
    logic       load_extend_sign;
    logic       wb_sel;
    logic       illegal;
  } ctrl_t;
  function automatic logic [5:0] arith_alu(input logic [2:0] f3, input logic [6:0] f7, input logic is_r);
    logic z, s, ok;
    z = f7 == 7'h00;
    s = f7 == 7'h20;
    ok = z || !is_r;
    case (f3)
      3'b000:  return (!is_r || z) ? ADD : s ? SUB : DEFAULT;
      3'b001:  return z ? SLL : DEFAULT;
      3'b010:  return ok ? SLT : DEFAULT;
      3'b011:  return ok ? SLTU : DEFAULT;
      3'b100:  return ok ? XOR : DEFAULT;
      3'b101:  return z ? SRL : s ? SRA : DEFAULT;
      3'b110:  return ok ? OR : DEFAULT;
      default: return ok ? AND : DEFAULT;
    endcase
  endfunction
  function automatic logic [5:0] branch_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return BEQ;
      3'b001:  return BNE;
      3'b100:  return BLT;
      3'b101:  return BGE;
      3'b110:  return BLTU;
      3'b111:  return BGEU;
      default: return DEFAULT;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// ctrl_decode_pipe_if: fetch-side and execute-side handshake plus the registered control bundle
interface ctrl_decode_pipe_if #(parameter int XLEN = 32, parameter int ALU_CTRL_W = 6);
  logic                  in_valid, in_ready, flush, out_valid, out_ready;
  logic [XLEN-1:0]       PC, out_PC;
  logic [31:0]           instruction, out_instruction, stall_count;
  logic                  wEn, branch_op, op_B_sel, mem_wEn, load_extend_sign, wb_sel, illegal;
  logic [1:0]            op_A_sel, MemSize;
  logic [ALU_CTRL_W-1:0] ALU_Control;
  modport master(
    output in_valid, PC, instruction, flush, out_ready,
    input  in_ready, out_valid, out_PC, out_instruction, stall_count, wEn, branch_op, op_B_sel,
           mem_wEn, load_extend_sign, wb_sel, illegal, op_A_sel, MemSize, ALU_Control
  );
  modport slave(
    input  in_valid, PC, instruction, flush, out_ready,
    output in_ready, out_valid, out_PC, out_instruction, stall_count, wEn, branch_op, op_B_sel,
           mem_wEn, load_extend_sign, wb_sel, illegal, op_A_sel, MemSize, ALU_Control
  );
endinterface

// File: rtl/ctrl_decode_pipe_load_scoreboard.sv
// load_scoreboard: per-register countdown of in-flight load results and rs1/rs2 busy lookup
module load_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       busy1,
  output logic       busy2
);
  localparam int CW = LOAD_LAT > 0 ? $clog2(LOAD_LAT + 1) : 1;
  logic [CW-1:0] cnt [NUM_REGS];
  // an issued load arms its rd; every other live counter drains by one per cycle
  always_ff @(posedge clock)
    for (int i = 0; i < NUM_REGS; i++)
      cnt[i] <= reset ? '0 : (set && int'(rd) == i) ? CW'(LOAD_LAT) : cnt[i] - CW'(cnt[i] != '0);
  assign busy1 = rs1 != 5'd0 && int'(rs1) < NUM_REGS && cnt[rs1] != '0;
  assign busy2 = rs2 != 5'd0 && int'(rs2) < NUM_REGS && cnt[rs2] != '0;
endmodule

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered RV32I ID stage with load-use stalls; CTRL_DECODE_PERF_EN adds a stall counter
module ctrl_decode_pipe
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int LOAD_LAT   = 2,
  parameter int ALU_CTRL_W = 6
) (
  input logic clock,
  input logic reset,
  ctrl_decode_pipe_if.slave bus
);
  logic [31:0]     ins, ins_q;
  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] pc_q;
  ctrl_t           d, q;
  logic            vld, use_rs1, use_rs2, busy1, busy2, hazard, accept, set_load;
  assign ins    = bus.instruction;
  assign opcode = ins[6:0];
  assign rd     = ins[11:7];
  assign f3     = ins[14:12];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign f7     = ins[31:25];
  // instruction to control bundle; unknown opcodes raise illegal with no side effects
  always_comb begin
    d = '0;
    d.alu = DEFAULT;
    case (opcode)
      R_TYPE: begin
        d.wEn = 1'b1;
        d.alu = arith_alu(f3, f7, 1'b1);
      end
      I_TYPE: begin
        d.wEn = 1'b1;
        d.op_B_sel = 1'b1;
        d.alu = arith_alu(f3, f7, 1'b0);
      end
      I_TYPE_LOAD: begin
        d.wEn = 1'b1;
        d.op_B_sel = 1'b1;
        d.wb_sel = 1'b1;
        d.mem_size = f3[1:0];
        d.load_extend_sign = !f3[2];
        d.alu = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101} ? ADD : DEFAULT;
      end
      S_TYPE: begin
        d.mem_wEn = 1'b1;
        d.op_B_sel = 1'b1;
        d.mem_size = f3[1:0];
        d.alu = f3 inside {3'b000, 3'b001, 3'b010} ? ADD : DEFAULT;
      end
      B_TYPE: begin
        d.branch_op = 1'b1;
        d.alu = branch_alu(f3);
      end
      J_JAL: begin
        d.wEn = 1'b1;
        d.op_A_sel = OPA_PC4;
        d.alu = JAL;
      end
      I_JALR: begin
        d.wEn = 1'b1;
        d.op_A_sel = OPA_PC4;
        d.op_B_sel = 1'b1;
        d.alu = f3 == 3'b000 ? JALR : DEFAULT;
      end
      U_AUIPC: begin
        d.wEn = 1'b1;
        d.op_A_sel = OPA_PC;
        d.op_B_sel = 1'b1;
        d.alu = ADD;
      end
      U_LUI: begin
        d.wEn = 1'b1;
        d.op_A_sel = OPA_ZERO;
        d.op_B_sel = 1'b1;
        d.alu = ADD;
      end
      default: d.illegal = 1'b1;
    endcase
  end
  assign use_rs1  = opcode inside {R_TYPE, I_TYPE, I_TYPE_LOAD, S_TYPE, B_TYPE, I_JALR};
  assign use_rs2  = opcode inside {R_TYPE, S_TYPE, B_TYPE};
  assign hazard   = (use_rs1 && busy1) || (use_rs2 && busy2);
  assign bus.in_ready = !hazard && !bus.flush && (!vld || bus.out_ready);
  assign accept   = bus.in_valid && bus.in_ready;
  assign set_load = accept && opcode == I_TYPE_LOAD && rd != 5'd0;
  load_scoreboard #(.NUM_REGS(NUM_REGS), .LOAD_LAT(LOAD_LAT)) sb (
    .clock(clock), .reset(reset), .set(set_load), .rd(rd), .rs1(rs1), .rs2(rs2),
    .busy1(busy1), .busy2(busy2)
  );
  // ID/EX register: load on accept, hold under back-pressure, drop on consume or flush
  always_ff @(posedge clock)
    if (reset) begin
      vld   <= 1'b0;
      q     <= '0;
      pc_q  <= '0;
      ins_q <= '0;
    end else begin
      vld <= accept || (vld && !bus.out_ready && !bus.flush);
      if (accept) begin
        q     <= d;
        pc_q  <= bus.PC;
        ins_q <= ins;
      end
    end
  assign bus.out_valid        = vld;
  assign bus.out_PC           = pc_q;
  assign bus.out_instruction  = ins_q;
  assign bus.wEn              = q.wEn;
  assign bus.branch_op        = q.branch_op;
  assign bus.op_A_sel         = q.op_A_sel;
  assign bus.op_B_sel         = q.op_B_sel;
  assign bus.ALU_Control      = ALU_CTRL_W'(q.alu);
  assign bus.mem_wEn          = q.mem_wEn;
  assign bus.MemSize          = q.mem_size;
  assign bus.load_extend_sign = q.load_extend_sign;
  assign bus.wb_sel           = q.wb_sel;
  assign bus.illegal          = q.illegal;
`ifdef CTRL_DECODE_PERF_EN
  logic [31:0] stalls;
  // counts cycles a valid fetch is held back by a load-use hazard
  always_ff @(posedge clock)
    stalls <= reset ? '0 : stalls + 32'(bus.in_valid && hazard && !bus.flush);
  assign bus.stall_count = stalls;
`else
  assign bus.stall_count = '0;
`endif
endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
Registered, parametrised successor to the combinational RV32I control decoder, and the ID stage of the pipelined core.
- Decodes PC + instruction into the control bundle: wEn, branch_op, op_A_sel, op_B_sel, ALU_Control, mem_wEn, MemSize, load_extend_sign, wb_sel.
- Holds the bundle in a valid/ready ID/EX register.
- Adds a load-use scoreboard that stalls dependent instructions, plus flush and illegal-opcode flagging.
- Sits between iFetch and Execute.

Parameters:
- XLEN, 32, PC/instruction width.
- NUM_REGS, 32, architectural register count; scoreboard depth.
- LOAD_LAT, 2, stall cycles a load's rd stays busy after issue; 0 disables stalling.
- ALU_CTRL_W, 6, ALU_Control width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch holds valid instruction
- in_ready  out  1  decode accepts this cycle
- PC  in  XLEN  fetch PC
- instruction  in  32  fetch instruction
- flush  in  1  branch/jump redirect; kill held bundle
- out_valid  out  1  bundle valid
- out_ready  in  1  Execute consumes bundle
- out_PC, out_instruction  out  XLEN/32  registered copies
- wEn, branch_op, op_B_sel, mem_wEn, load_extend_sign, wb_sel  out  1 each  registered controls
- op_A_sel  out  2  00 rs1, 01 PC, 10 PC+4, 11 zero
- ALU_Control  out  ALU_CTRL_W  ALU op
- MemSize  out  2  byte/hword/word
- illegal  out  1  opcode not recognised
- stall_count  out  32  load-use stall cycles (optional feature)

Behaviour:
- Reset, synchronous, highest priority: out_valid=0, every control output 0, illegal=0, stall_count=0, all scoreboard counters 0.
- Decode (combinational, then registered): same opcode/funct3/funct7 mapping as the existing decoder, with every output driven in every path.
  - Unlisted funct3/funct7 gives ALU_Control=DEFAULT.
  - lw sets load_extend_sign=1.
  - AUIPC drives branch_op=0.
  - Unknown opcode: illegal=1, wEn=0, mem_wEn=0, branch_op=0.
- Hazard is 1 when the decoded instruction reads rs1 (R, I, load, S, B, JALR) or rs2 (R, S, B), that register is not x0, and its scoreboard counter is nonzero.
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Accept when in_valid && in_ready: bundle loads on the next edge, out_valid=1. Latency 1 cycle.
- When out_valid && out_ready and nothing is accepted, out_valid<=0.
- flush: out_valid<=0 on the edge. The scoreboard is not rolled back (conservative). flush overrides any accept.
- Scoreboard: one counter per register, width clog2(LOAD_LAT+1).
  - Accepting a load with rd!=0 sets counter[rd]=LOAD_LAT.
  - Every other nonzero counter decrements by 1 per cycle, saturating at 0.
  - Set and decrement on the same register in the same cycle: set wins.
- Back-pressure (out_ready=0): bundle and outputs hold stable; counters keep decrementing.
- Reset mid-stall drops the held bundle and clears all counters.

Optional Feature:
- Macro CTRL_DECODE_PERF_EN.
- Defined: stall_count increments by 1 each cycle with in_valid && hazard && !flush; wraps at 2^32; cleared by reset.
- Undefined: stall_count is tied to 0 and the counter logic is absent.

Decomposition:
- Shared package/header holds:
  - opcode macros R_TYPE, I_TYPE, I_TYPE_LOAD, S_TYPE, B_TYPE, I_JALR, J_JAL, U_AUIPC, U_LUI.
  - ALU op codes ADD..BGEU, JAL, JALR, DEFAULT.
  - SIZE_BYTE/HWORD/WORD.
  - op_A_sel encodings.
- One natural sub-module: load_scoreboard, holding the counters, set/decrement logic and the rs1/rs2 busy lookup.
- Decode logic stays in ctrl_decode_pipe.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1 -> out_valid=0, all controls 0, in_ready=1 after release.
- Load-use (LOAD_LAT=2): lw x5,0(x1) (0x0000A283), then add x6,x5,x5 (0x00528333), out_ready=1 -> add stalls exactly 2 cycles, accepted on the 3rd; stall_count=2 with macro.
- Decode: addi x1,x0,5 (0x00500093) -> wEn=1, op_B_sel=1, op_A_sel=00, ALU_Control=ADD, wb_sel=0, illegal=0 one cycle after accept.
- Back-pressure: out_ready=0 for 3 cycles with a held bundle -> in_ready=0, outputs stable; out_ready=1 -> next instruction accepted same cycle.
- Flush: flush=1 while a bundle is held and in_valid=1 -> out_valid=0 next cycle, no accept that cycle.
- Illegal: instruction 0x0000007F -> illegal=1, wEn=0, mem_wEn=0, out_valid=1.
